// File: rtl/c4_pkg.sv
// c4_pkg: shared Connect 4 constants, column type and move-input FSM states
package c4_pkg;
    localparam int NUM_COLS_DEFAULT = 7;
    localparam int NUM_ROWS = 6;
    typedef logic [2:0] col_t;
    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, WAIT_REL} in_state_t;
endpackage

// File: rtl/c4_debounce.sv
// c4_debounce: 2-flop synchroniser plus stable-for-CYCLES filter on a WIDTH-bit vector
module c4_debounce #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic             settled
);
    localparam int CW = $clog2(CYCLES);
    logic [WIDTH-1:0] s1, s2, cand;
    logic [CW-1:0]    cnt;
    // settled marks that at least one value has been committed since reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            cand    <= '0;
            cnt     <= '0;
            stable  <= '0;
            settled <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                stable  <= cand;
                settled <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/c4_move_input.sv
// c4_move_input: debounced column/drop-key front end issuing one validated column-drop
// command per press over a valid/ready handshake
module c4_move_input
    import c4_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_COLS        = NUM_COLS_DEFAULT
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [2:0]          col_sw,
    input  logic                drop_key_n,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                move_ready,
    output logic                move_valid,
    output logic [2:0]          move_col,
    output logic                move_reject,
    output logic [2:0]          col_preview
);
    logic      key_db, key_settled, col_settled, key_q, armed, press, bad;
    col_t      col_db, col_q;
    logic [7:0] full_ext;
    in_state_t state, state_d;

    c4_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk(CLOCK_50), .rst_n(resetn), .raw(~drop_key_n),
        .stable(key_db), .settled(key_settled)
    );

    c4_debounce #(.WIDTH(3), .CYCLES(DEBOUNCE_CYCLES)) u_col (
        .clk(CLOCK_50), .rst_n(resetn), .raw(col_sw),
        .stable(col_db), .settled(col_settled)
    );

    // columns at or beyond NUM_COLS read as permanently full
    assign full_ext   = 8'(col_full) | ~8'((1 << NUM_COLS) - 1);
    assign bad        = full_ext[col_q];
    // a press only counts once the key has been seen settled-released after reset
    assign press      = key_db & ~key_q & armed;
    assign move_valid = state == ISSUE;
    assign move_col   = col_q;

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:     state_d = press ? CHECK : IDLE;
            CHECK:    state_d = bad ? WAIT_REL : ISSUE;
            ISSUE:    state_d = move_ready ? WAIT_REL : ISSUE;
            WAIT_REL: state_d = key_db ? WAIT_REL : IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            key_q       <= 1'b0;
            armed       <= 1'b0;
            col_q       <= '0;
            move_reject <= 1'b0;
            col_preview <= '0;
        end else begin
            state       <= state_d;
            key_q       <= key_db;
            armed       <= armed | (key_settled & col_settled & ~key_db);
            col_q       <= (state == IDLE && press) ? col_db : col_q;
            move_reject <= state == CHECK && bad;
            col_preview <= col_db;
        end
    end
endmodule

// File: tb/tb_c4_move_input.sv
// tb_c4_move_input: directed scenario bench for c4_move_input with DEBOUNCE_CYCLES=4
module tb_c4_move_input;
    logic       CLOCK_50, resetn, drop_key_n, move_ready;
    logic [2:0] col_sw;
    logic [6:0] col_full;
    logic       move_valid, move_reject;
    logic [2:0] move_col, col_preview;
    int vectors = 0, errors = 0;
    int xfers = 0, vcyc = 0, rej = 0;
    logic [2:0] last_col = '0;

    c4_move_input #(.DEBOUNCE_CYCLES(4), .NUM_COLS(7)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .col_sw(col_sw), .drop_key_n(drop_key_n),
        .col_full(col_full), .move_ready(move_ready), .move_valid(move_valid),
        .move_col(move_col), .move_reject(move_reject), .col_preview(col_preview)
    );

    initial begin
        CLOCK_50 = 0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) begin
        if (resetn) begin
            if (move_valid && move_ready) begin
                xfers    <= xfers + 1;
                last_col <= move_col;
            end
            if (move_valid) vcyc <= vcyc + 1;
            if (move_reject) rej <= rej + 1;
        end
    end

    task automatic hold_key(input int n);
        drop_key_n = 0;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic release_key();
        drop_key_n = 1;
        repeat (12) @(negedge CLOCK_50);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (move_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 0; drop_key_n = 1; col_sw = 0; col_full = 0; move_ready = 1;
        repeat (3) @(negedge CLOCK_50);
        vectors++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", move_valid); end
        vectors++; if (move_col !== 3'd0) begin errors++; $display("FAIL reset_col got %0d want 0", move_col); end
        vectors++; if (move_reject !== 1'b0) begin errors++; $display("FAIL reset_reject got %b want 0", move_reject); end
        vectors++; if (col_preview !== 3'd0) begin errors++; $display("FAIL reset_preview got %0d want 0", col_preview); end
        resetn = 1;
        repeat (12) @(negedge CLOCK_50);
        vectors++; if (move_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", move_valid); end
    endtask

    task automatic test_clean_press();
        int x0, v0, r0;
        col_sw = 3; col_full = 0; move_ready = 1;
        repeat (12) @(negedge CLOCK_50);
        vectors++; if (col_preview !== 3'd3) begin errors++; $display("FAIL preview3 got %0d want 3", col_preview); end
        x0 = xfers; v0 = vcyc; r0 = rej;
        hold_key(20);
        release_key();
        vectors++; if (xfers - x0 != 1) begin errors++; $display("FAIL clean_xfers got %0d want 1", xfers - x0); end
        vectors++; if (vcyc - v0 != 1) begin errors++; $display("FAIL clean_valid_cycles got %0d want 1", vcyc - v0); end
        vectors++; if (last_col !== 3'd3) begin errors++; $display("FAIL clean_col got %0d want 3", last_col); end
        vectors++; if (rej - r0 != 0) begin errors++; $display("FAIL clean_reject got %0d want 0", rej - r0); end
    endtask

    task automatic test_backpressure();
        int x0;
        bit ok;
        col_sw = 3; move_ready = 0;
        x0 = xfers;
        drop_key_n = 0;
        wait_valid(ok);
        vectors++; if (!ok) begin errors++; $display("FAIL bp_timeout got 0 want 1"); end
        col_sw = 5;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            vectors++;
            if (move_valid !== 1'b1 || move_col !== 3'd3) begin
                errors++; $display("FAIL bp_hold cyc %0d got v=%b c=%0d want v=1 c=3", i, move_valid, move_col);
            end
        end
        move_ready = 1;
        @(negedge CLOCK_50);
        vectors++; if (move_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", move_valid); end
        vectors++; if (last_col !== 3'd3) begin errors++; $display("FAIL bp_col got %0d want 3", last_col); end
        repeat (20) @(negedge CLOCK_50);
        release_key();
        vectors++; if (xfers - x0 != 1) begin errors++; $display("FAIL bp_xfers got %0d want 1", xfers - x0); end
        vectors++; if (col_preview !== 3'd5) begin errors++; $display("FAIL preview5 got %0d want 5", col_preview); end
    endtask

    task automatic test_reject();
        int v0, r0;
        col_sw = 2; col_full = 7'b0000100; move_ready = 1;
        repeat (12) @(negedge CLOCK_50);
        v0 = vcyc; r0 = rej;
        hold_key(15);
        release_key();
        vectors++; if (rej - r0 != 1) begin errors++; $display("FAIL full_reject got %0d want 1", rej - r0); end
        vectors++; if (vcyc - v0 != 0) begin errors++; $display("FAIL full_valid got %0d want 0", vcyc - v0); end
        col_sw = 7; col_full = 0;
        repeat (12) @(negedge CLOCK_50);
        v0 = vcyc; r0 = rej;
        hold_key(15);
        release_key();
        vectors++; if (rej - r0 != 1) begin errors++; $display("FAIL col7_reject got %0d want 1", rej - r0); end
        vectors++; if (vcyc - v0 != 0) begin errors++; $display("FAIL col7_valid got %0d want 0", vcyc - v0); end
    endtask

    task automatic test_bounce();
        int v0, r0, x0;
        col_sw = 1; col_full = 0; move_ready = 1;
        repeat (12) @(negedge CLOCK_50);
        v0 = vcyc; r0 = rej;
        for (int i = 0; i < 15; i++) begin
            drop_key_n = i[0];
            repeat (2) @(negedge CLOCK_50);
        end
        release_key();
        vectors++; if (vcyc - v0 != 0) begin errors++; $display("FAIL bounce_valid got %0d want 0", vcyc - v0); end
        vectors++; if (rej - r0 != 0) begin errors++; $display("FAIL bounce_reject got %0d want 0", rej - r0); end
        x0 = xfers;
        for (int i = 0; i < 5; i++) begin
            drop_key_n = i[0];
            repeat (2) @(negedge CLOCK_50);
        end
        hold_key(20);
        release_key();
        vectors++; if (xfers - x0 != 1) begin errors++; $display("FAIL bounce_press got %0d want 1", xfers - x0); end
        vectors++; if (last_col !== 3'd1) begin errors++; $display("FAIL bounce_col got %0d want 1", last_col); end
    endtask

    task automatic test_long_hold();
        int x0, v0;
        col_sw = 6; col_full = 0; move_ready = 1;
        repeat (12) @(negedge CLOCK_50);
        x0 = xfers; v0 = vcyc;
        hold_key(1000);
        vectors++; if (xfers - x0 != 1) begin errors++; $display("FAIL hold_xfers got %0d want 1", xfers - x0); end
        vectors++; if (vcyc - v0 != 1) begin errors++; $display("FAIL hold_valid got %0d want 1", vcyc - v0); end
        release_key();
        hold_key(20);
        release_key();
        vectors++; if (xfers - x0 != 2) begin errors++; $display("FAIL repress_xfers got %0d want 2", xfers - x0); end
        vectors++; if (last_col !== 3'd6) begin errors++; $display("FAIL repress_col got %0d want 6", last_col); end
    endtask

    task automatic test_reset_mid_issue();
        int x0, v0;
        bit ok;
        col_sw = 4; col_full = 0; move_ready = 0;
        repeat (12) @(negedge CLOCK_50);
        drop_key_n = 0;
        wait_valid(ok);
        vectors++; if (!ok) begin errors++; $display("FAIL rst_timeout got 0 want 1"); end
        resetn = 0;
        #1;
        vectors++; if (move_valid !== 1'b0) begin errors++; $display("FAIL async_drop got %b want 0", move_valid); end
        vectors++; if (move_col !== 3'd0) begin errors++; $display("FAIL async_col got %0d want 0", move_col); end
        repeat (3) @(negedge CLOCK_50);
        x0 = xfers; v0 = vcyc;
        resetn = 1; move_ready = 1;
        repeat (30) @(negedge CLOCK_50);
        vectors++; if (vcyc - v0 != 0) begin errors++; $display("FAIL held_rst_valid got %0d want 0", vcyc - v0); end
        release_key();
        hold_key(20);
        release_key();
        vectors++; if (xfers - x0 != 1) begin errors++; $display("FAIL rst_repress got %0d want 1", xfers - x0); end
        vectors++; if (last_col !== 3'd4) begin errors++; $display("FAIL rst_col got %0d want 4", last_col); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_backpressure();
        test_reject();
        test_bounce();
        test_long_hold();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/c4_move_input.md
Name: c4_move_input

Overview:
- Upstream front end for the Connect 4 game engine on the DE-series board.
- Conditions the raw column switches and the "drop" pushbutton, debouncing and synchronising both.
- Validates the requested column against the engine's column-full flags.
- Delivers exactly one column-drop command per physical button press over a valid/ready handshake. Rejected presses raise a one-cycle pulse used for LED/HEX feedback.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised input must stay stable before it is accepted (20 ms at 50 MHz); legal range 2 to 2^24-1.
- NUM_COLS, 7, number of board columns; legal column indices are 0..NUM_COLS-1.

Ports:
- CLOCK_50 in 1: system clock, 50 MHz.
- resetn in 1: asynchronous, active-low reset.
- col_sw in 3: raw column-select switches (SW[2:0]), asynchronous.
- drop_key_n in 1: raw drop pushbutton (KEY[1]), active-low, asynchronous.
- col_full in NUM_COLS: from the engine; bit i = 1 means column i is full.
- move_ready in 1: engine can accept a move this cycle.
- move_valid out 1: a move command is presented.
- move_col out 3: column of the presented move.
- move_reject out 1: one-cycle pulse when a press was refused.
- col_preview out 3: debounced current switch value, for the display.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, synchronisers and debounce counters cleared. Debounced key state resets to "released"; debounced column resets to 0.
- Synchronisation: 2-flop synchroniser on drop_key_n and on each col_sw bit. The synchronised key is inverted so that press = 1.
- Debounce, per input:
  - The counter restarts on any change of the synchronised value.
  - The stable value is committed when the counter reaches DEBOUNCE_CYCLES-1.
  - Column bits are debounced as one 3-bit vector: any bit change restarts the counter.
- Press event: 1-cycle pulse on the debounced key's 0->1 transition. Release produces no event.
- col_preview tracks the debounced column continuously, with 1-cycle register latency.
- FSM states: IDLE, CHECK, ISSUE, WAIT_REL.
  - IDLE: on press event, latch the debounced column into col_q, go to CHECK.
  - CHECK (1 cycle):
    - If col_q >= NUM_COLS or col_full[col_q] = 1: pulse move_reject next cycle, go to WAIT_REL.
    - Otherwise go to ISSUE.
  - ISSUE:
    - move_valid = 1 and move_col = col_q; both stay constant until the handshake.
    - The transfer occurs in a cycle where move_valid and move_ready are both 1. Next state is WAIT_REL with move_valid = 0.
    - move_ready is sampled only in ISSUE.
  - WAIT_REL: stay until the debounced key reads released, then go to IDLE.
- Latency: press event -> move_valid = 1 in 2 cycles (IDLE->CHECK->ISSUE).
- Boundary conditions:
  - Switch change while in CHECK/ISSUE/WAIT_REL does not alter col_q or move_col.
  - col_full is sampled only in CHECK. If the column fills during ISSUE, the command is still held; the engine is responsible.
  - Key held indefinitely produces exactly one command.
  - Key bounce shorter than DEBOUNCE_CYCLES produces no event.
  - Press and release within one debounce window produce no event.
  - resetn asserted mid-ISSUE: move_valid drops immediately (asynchronously). No command is replayed after release of reset.
  - If the key is held through reset, no event fires until it is released and pressed again, because the debounced state starts "released" and must first be seen released.
- Widths: counters are $clog2(DEBOUNCE_CYCLES) bits. Column compare is unsigned 3-bit.

Decomposition:
- Shared package c4_pkg holds:
  - NUM_COLS_DEFAULT = 7, NUM_ROWS = 6.
  - col_t as a 3-bit typedef.
  - the input FSM state enum (IDLE, CHECK, ISSUE, WAIT_REL).
- Sub-module c4_debounce, parameterised by WIDTH and CYCLES: synchroniser plus stable counter. Instantiated twice: WIDTH=1 for the key, WIDTH=3 for the switches.
- The FSM and handshake logic stay in c4_move_input.

Test Plan (DEBOUNCE_CYCLES=4):
1. Set col_sw=3, col_full=0, move_ready=1; press key clean for 20 cycles -> exactly one cycle with move_valid=1, move_col=3; move_reject stays 0.
2. Set move_ready=0 for 10 cycles after move_valid rises, while switching col_sw to 5 -> move_valid and move_col=3 held constant; handshake completes on the first move_ready=1; no second command.
3. Drive col_sw=2 with col_full=7'b0000100 and press -> move_reject pulses exactly 1 cycle and move_valid never rises. Same with col_sw=7 and col_full=0 -> reject.
4. Bounce the key 1/0 with 2-cycle periods for 30 cycles, then release -> no move_valid, no move_reject. Then bounce before a stable press -> exactly one command.
5. Hold the key 1000 cycles -> one command. Release, then press again -> a second command.
6. Assert resetn=0 during ISSUE -> move_valid=0 in the same cycle. Release reset with the key still held -> no command until release and re-press.
